quantizer_im_fetch: RTL and testbench
=====================================

QUANTIZER_IM_FETCH -- requirements
Module: quantizer_im_fetch

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, bit width of the unsigned sample input.
REQ-002 SHALL have parameter HV_WIDTH, default 64, bit width of each item-memory hypervector.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port nrst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1 bit: sample-valid qualifier for input_value.
REQ-007 SHALL have port input_value, input, IN_WIDTH bits: unsigned sample to quantize.
REQ-008 SHALL have ports im1..im10, input, HV_WIDTH bits each: level hypervectors for levels 0..9 (im1 = level 0, im10 = level 9).
REQ-009 SHALL have port quantized_value_level, output, 4 bits: registered quantization level, range 0..9.
REQ-010 SHALL have port level_hv, output, HV_WIDTH bits: registered hypervector of the level.
REQ-011 SHALL have port hv_valid, output, 1 bit: level_hv updated this cycle from a new sample.

Function
REQ-012 SHALL compute level = (input_value * 10) >> IN_WIDTH, using a full-width product (IN_WIDTH+4 bits) with no truncation before the shift.
REQ-013 SHALL map 16-bit lower bounds for levels 1..9 to 6554, 13108, 19661, 26215, 32768, 39322, 45876, 52429, 58983 (inclusive); 0..6553 is level 0 and 65535 is level 9.
REQ-014 SHALL be a two-stage pipeline: stage 1 registers the level; stage 2 registers the fetched hypervector.
REQ-015 Stage 1: on a rising edge with en=1, SHALL set quantized_value_level to the level of the current input_value and the internal flag v1 to 1.
REQ-016 Stage 1: on a rising edge with en=0, SHALL hold quantized_value_level and set v1 to 0.
REQ-017 Stage 2: on a rising edge with v1=1, SHALL set level_hv to im(level+1), sampling the im ports at that edge, with level = current quantized_value_level.
REQ-018 Stage 2: on a rising edge with v1=0, SHALL hold level_hv.
REQ-019 SHALL set hv_valid to the value v1 had before each rising edge.
REQ-020 Latency SHALL be 2 clocks: a sample taken at edge N appears on level_hv, with hv_valid=1, after edge N+1.
REQ-021 SHALL accept one sample per clock with no bubbles: consecutive en=1 cycles give consecutive hv_valid=1 cycles.
REQ-022 SHALL select all-zero level_hv for a level value of 10..15, which is unreachable by REQ-012.
REQ-023 SHALL have no combinational path from any input to any output.

Reset
REQ-024 While nrst=0, quantized_value_level, v1, level_hv and hv_valid SHALL be 0, asynchronously and regardless of clk and en.
REQ-025 After nrst rises, the first sample SHALL be taken at the first rising edge with en=1.
REQ-026 Reset mid-operation SHALL discard in-flight samples: no hv_valid pulse follows for samples taken before reset.

Verification
REQ-027 Reset: assert nrst=0 with en=1, input_value=40000 -> quantized_value_level=0, level_hv=0, hv_valid=0 during reset.
REQ-028 Boundaries: inputs 0, 6553, 6554, 32767, 32768, 58982, 58983, 65535 -> levels 0, 0, 1, 4, 5, 8, 9, 9.
REQ-029 Fetch: im1..im10 = 0..9, inputs 0, 20000, 65535 on three consecutive en=1 edges -> level_hv = 0, 3, 9 on three consecutive cycles, each 2 clocks after its sample, hv_valid=1 for all three.
REQ-030 Stall: en=1 for one edge with input 45876, then en=0 with input 0 -> level stays 7, level_hv=im8 with a single-cycle hv_valid pulse, then level_hv holds.
REQ-031 Mid-pipeline reset: sample at edge N, nrst=0 between edges N and N+1 -> level_hv=0 and hv_valid stays 0 after release.
REQ-032 Live memory: change im6 between sample edge N and edge N+1 for input 32768 -> level_hv equals the im6 value present at edge N+1.

Source files
------------

// File: rtl/quantizer_im_fetch.sv
// Two-stage sample quantizer: stage 1 maps an unsigned sample to one of ten levels,
// stage 2 fetches that level's hypervector from the live item-memory ports.
module quantizer_im_fetch #(
  parameter int IN_WIDTH = 16,
  parameter int HV_WIDTH = 64
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic [IN_WIDTH-1:0] input_value,
  input  logic [HV_WIDTH-1:0] im1,
  input  logic [HV_WIDTH-1:0] im2,
  input  logic [HV_WIDTH-1:0] im3,
  input  logic [HV_WIDTH-1:0] im4,
  input  logic [HV_WIDTH-1:0] im5,
  input  logic [HV_WIDTH-1:0] im6,
  input  logic [HV_WIDTH-1:0] im7,
  input  logic [HV_WIDTH-1:0] im8,
  input  logic [HV_WIDTH-1:0] im9,
  input  logic [HV_WIDTH-1:0] im10,
  output logic [3:0]          quantized_value_level,
  output logic [HV_WIDTH-1:0] level_hv,
  output logic                hv_valid
);

  localparam int PW = IN_WIDTH + 4;

  // Handshake: en qualifies input_value for one edge; hv_valid is a one-cycle
  // strobe two edges later marking level_hv as freshly fetched. No backpressure.

  logic [PW-1:0]       product;
  logic [3:0]          level_d, level_q;
  logic                v1_d, v1_q;
  logic [HV_WIDTH-1:0] hv_sel;
  logic [HV_WIDTH-1:0] hv_d, hv_q;
  logic                hv_valid_d, hv_valid_q;

  // Full-width product so the top four bits are exactly floor(x*10 / 2^IN_WIDTH).
  assign product = PW'(input_value) * PW'(10);

  always_comb begin
    level_d = level_q;
    v1_d    = en;
    if (en) begin
      level_d = product[PW-1 -: 4];
    end
  end

  always_comb begin
    hv_sel = '0;
    case (level_q)
      4'd0:    hv_sel = im1;
      4'd1:    hv_sel = im2;
      4'd2:    hv_sel = im3;
      4'd3:    hv_sel = im4;
      4'd4:    hv_sel = im5;
      4'd5:    hv_sel = im6;
      4'd6:    hv_sel = im7;
      4'd7:    hv_sel = im8;
      4'd8:    hv_sel = im9;
      4'd9:    hv_sel = im10;
      default: hv_sel = '0;
    endcase
  end

  always_comb begin
    hv_d       = hv_q;
    hv_valid_d = v1_q;
    if (v1_q) begin
      hv_d = hv_sel;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      level_q    <= '0;
      v1_q       <= 1'b0;
      hv_q       <= '0;
      hv_valid_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      v1_q       <= v1_d;
      hv_q       <= hv_d;
      hv_valid_q <= hv_valid_d;
    end
  end

  assign quantized_value_level = level_q;
  assign level_hv              = hv_q;
  assign hv_valid              = hv_valid_q;

endmodule

// File: tb/tb_quantizer_im_fetch.sv
// Directed plus randomized checks of quantizer_im_fetch against a level/queue model.
module tb_quantizer_im_fetch;

  logic        clk;
  logic        nrst;
  logic        en;
  logic [15:0] input_value;
  logic [63:0] im [10];
  logic [3:0]  quantized_value_level;
  logic [63:0] level_hv;
  logic        hv_valid;

  int checks;
  int failures;

  quantizer_im_fetch #(.IN_WIDTH(16), .HV_WIDTH(64)) dut (
    .clk(clk), .nrst(nrst), .en(en), .input_value(input_value),
    .im1(im[0]), .im2(im[1]), .im3(im[2]), .im4(im[3]), .im5(im[4]),
    .im6(im[5]), .im7(im[6]), .im8(im[7]), .im9(im[8]), .im10(im[9]),
    .quantized_value_level(quantized_value_level),
    .level_hv(level_hv), .hv_valid(hv_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_level(input int x);
    return (x * 10) / 65536;
  endfunction

  // scoreboard state for the random phase
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_level;
  logic [63:0] exp_hv;
  logic        exp_valid;

  int bounds_in [8] = '{0, 6553, 6554, 32767, 32768, 58982, 58983, 65535};
  int bounds_lv [8] = '{0, 0, 1, 4, 5, 8, 9, 9};
  logic [63:0] live_val;

  initial begin
    checks = 0;
    failures = 0;
    for (int k = 0; k < 10; k++) im[k] = 64'(k);

    // reset held with en active
    nrst = 1'b0;
    en = 1'b1;
    input_value = 16'd40000;
    repeat (3) step();
    check("rst_level", 64'(quantized_value_level), 64'd0);
    check("rst_hv", level_hv, 64'd0);
    check("rst_valid", 64'(hv_valid), 64'd0);
    en = 1'b0;
    nrst = 1'b1;
    step();
    check("post_rst_valid", 64'(hv_valid), 64'd0);

    // level boundaries
    for (int i = 0; i < 8; i++) begin
      en = 1'b1;
      input_value = 16'(bounds_in[i]);
      step();
      check($sformatf("bound_%0d", bounds_in[i]), 64'(quantized_value_level), 64'(bounds_lv[i]));
    end
    en = 1'b0;
    repeat (2) step();

    // back-to-back fetch
    en = 1'b1;
    input_value = 16'd0;
    step();
    input_value = 16'd20000;
    step();
    check("fetch0_hv", level_hv, 64'd0);
    check("fetch0_valid", 64'(hv_valid), 64'd1);
    input_value = 16'd65535;
    step();
    check("fetch1_hv", level_hv, 64'd3);
    check("fetch1_valid", 64'(hv_valid), 64'd1);
    en = 1'b0;
    step();
    check("fetch2_hv", level_hv, 64'd9);
    check("fetch2_valid", 64'(hv_valid), 64'd1);
    step();
    check("fetch_end_valid", 64'(hv_valid), 64'd0);

    // stall after single sample
    en = 1'b1;
    input_value = 16'd45876;
    step();
    check("stall_level", 64'(quantized_value_level), 64'd7);
    en = 1'b0;
    input_value = 16'd0;
    step();
    check("stall_level_hold", 64'(quantized_value_level), 64'd7);
    check("stall_hv", level_hv, 64'd7);
    check("stall_valid", 64'(hv_valid), 64'd1);
    step();
    check("stall_hv_hold", level_hv, 64'd7);
    check("stall_valid_drop", 64'(hv_valid), 64'd0);
    check("stall_level_hold2", 64'(quantized_value_level), 64'd7);

    // reset between sample edge and fetch edge
    en = 1'b1;
    input_value = 16'd65535;
    step();
    en = 1'b0;
    #1 nrst = 1'b0;
    #1;
    check("midrst_level", 64'(quantized_value_level), 64'd0);
    check("midrst_hv", level_hv, 64'd0);
    #1 nrst = 1'b1;
    step();
    check("midrst_hv_after", level_hv, 64'd0);
    check("midrst_valid_after", 64'(hv_valid), 64'd0);
    step();
    check("midrst_valid_after2", 64'(hv_valid), 64'd0);

    // item memory sampled at the fetch edge, not the sample edge
    en = 1'b1;
    input_value = 16'd32768;
    step();
    en = 1'b0;
    live_val = 64'hdead_beef_0bad_f00d;
    im[5] = live_val;
    step();
    check("live_hv", level_hv, live_val);
    check("live_valid", 64'(hv_valid), 64'd1);

    // randomized traffic from a clean reset
    nrst = 1'b0;
    #1 nrst = 1'b1;
    exp_q.delete();
    exp_level = '0;
    exp_hv = '0;
    exp_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      en = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0)
        input_value = 16'(bounds_in[$urandom_range(0, 7)]);
      else
        input_value = 16'($urandom);
      for (int k = 0; k < 10; k++) im[k] = {$urandom, $urandom};
      step();
      // sample taken one edge ago is fetched now using the memory at this edge
      if (exp_q.size() > 0) begin
        exp_hv = im[exp_q.pop_front()];
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (en) begin
        exp_level = 4'(ref_level(int'(input_value)));
        exp_q.push_back(exp_level);
      end
      check("rnd_level", 64'(quantized_value_level), 64'(exp_level));
      check("rnd_valid", 64'(hv_valid), 64'(exp_valid));
      check("rnd_hv", level_hv, exp_hv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
